// File: rtl/dm_pkg.sv
// dm_pkg: dmcontrol bit positions and hartsel helpers shared by the debug-module control files
package dm_pkg;
    localparam int HALTREQ         = 31;
    localparam int RESUMEREQ       = 30;
    localparam int HARTRESET       = 29;
    localparam int ACKHAVERESET    = 28;
    localparam int HASEL           = 26;
    localparam int HARTSELLO_HI    = 25;
    localparam int HARTSELLO_LO    = 16;
    localparam int HARTSELHI_HI    = 15;
    localparam int HARTSELHI_LO    = 6;
    localparam int SETRESETHALTREQ = 3;
    localparam int CLRRESETHALTREQ = 2;
    localparam int NDMRESET        = 1;
    localparam int DMACTIVE        = 0;
    localparam int HARTSEL_MAX_W   = 20;

    // Reassemble the 20-bit hartsel from its split hi/lo dmcontrol fields.
    function automatic logic [HARTSEL_MAX_W-1:0] get_hartsel(input logic [31:0] w);
        return {w[HARTSELHI_HI:HARTSELHI_LO], w[HARTSELLO_HI:HARTSELLO_LO]};
    endfunction

    // Scatter a 20-bit hartsel back into the dmcontrol hi/lo field positions.
    function automatic logic [31:0] put_hartsel(input logic [HARTSEL_MAX_W-1:0] h);
        logic [31:0] w;
        w = '0;
        w[HARTSELLO_HI:HARTSELLO_LO] = h[9:0];
        w[HARTSELHI_HI:HARTSELHI_LO] = h[19:10];
        return w;
    endfunction
endpackage

// File: rtl/dm_control_unit_if.sv
// dm_control_unit_if: DMI-side dmcontrol write/readback bundle between register decoder and control unit
interface dm_control_unit_if;
    logic        dmi_wr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmcont_reg;

    modport master (output dmi_wr, dmi_wdata, input dmcont_reg);
    modport slave  (input dmi_wr, dmi_wdata, output dmcont_reg);
endinterface

// File: rtl/dm_hartsel_decode.sv
// dm_hartsel_decode: hartsel (plus optional hart-array mask) to per-hart selection mask and nonexistent flag
module dm_hartsel_decode
    import dm_pkg::*;
#(
    parameter int NHARTS = 4
) (
    input  logic [HARTSEL_MAX_W-1:0] hartsel_i,
    input  logic [NHARTS-1:0]        mask_i,
    output logic [NHARTS-1:0]        sel_o,
    output logic                     nonexistent_o
);
    // One-hot decode of the selected index, widened by the array mask.
    always_comb begin
        sel_o = mask_i;
        for (int i = 0; i < NHARTS; i++) begin
            if (hartsel_i == HARTSEL_MAX_W'(i)) sel_o[i] = 1'b1;
        end
    end

    assign nonexistent_o = 32'(hartsel_i) >= 32'(NHARTS);
endmodule

// File: rtl/dm_control_unit.sv
// dm_control_unit: registered dmcontrol driving per-hart halt/resume/reset requests and sticky status.
// Optional hart-array selection is built when DM_HART_ARRAY_EN is defined (adds hawindow_i).
module dm_control_unit
    import dm_pkg::*;
#(
    parameter int NHARTS    = 4,
    parameter int HARTSEL_W = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    dm_control_unit_if.slave    dmi,
`ifdef DM_HART_ARRAY_EN
    input  logic [NHARTS-1:0]   hawindow_i,
`endif
    output logic [NHARTS-1:0]   halt_req_o,
    output logic [NHARTS-1:0]   resume_req_o,
    output logic [NHARTS-1:0]   hart_reset_o,
    output logic                ndmreset_o,
    output logic [NHARTS-1:0]   resethaltreq_o,
    input  logic [NHARTS-1:0]   hart_halted_i,
    input  logic [NHARTS-1:0]   resume_ack_i,
    input  logic [NHARTS-1:0]   hart_reset_done_i,
    output logic                sel_nonexistent_o,
    output logic                any_halted_o,
    output logic                all_halted_o,
    output logic                any_resumeack_o,
    output logic                all_resumeack_o,
    output logic                any_havereset_o,
    output logic                all_havereset_o
);
    logic                     dmactive_q, dmactive_d, ndmreset_q, ndmreset_d, act;
    logic [HARTSEL_W-1:0]     hartsel_q, hartsel_d;
    logic [NHARTS-1:0]        halt_q, halt_d, pend_q, pend_d, rack_q, rack_d;
    logic [NHARTS-1:0]        haverst_q, haverst_d, rhr_q, rhr_d, hrst_q, hrst_d;
    logic [NHARTS-1:0]        mask_wr, mask_lat, sel_wr, sel_lat;
    logic [HARTSEL_MAX_W-1:0] hs_mask, hs_wr, hs_lat;
    logic [31:0]              w, rd;
    logic                     wr, hasel_rd, nonexist_lat, resume_ok, rd_halt, rd_hrst;
    logic                     unused_wr_nonexist, unused_bits;

    assign wr        = dmi.dmi_wr;
    assign w         = dmi.dmi_wdata;
    // Only HARTSEL_W low bits of hartsel are implemented; the rest read and act as zero.
    assign hs_mask   = HARTSEL_MAX_W'((64'd1 << HARTSEL_W) - 64'd1);
    assign hs_wr     = get_hartsel(w) & hs_mask;
    assign hs_lat    = HARTSEL_MAX_W'(hartsel_q);
    assign resume_ok = w[RESUMEREQ] & ~w[HALTREQ];

`ifdef DM_HART_ARRAY_EN
    logic              hasel_q, hasel_d;
    logic [NHARTS-1:0] hamask_q, hamask_d;

    // The array mask is refreshed from the sideband window on every hasel=1 write.
    always_comb begin
        hasel_d  = act & (wr ? w[HASEL] : hasel_q);
        hamask_d = ~act ? '0 : (wr & w[HASEL]) ? hawindow_i : hamask_q;
    end

    // Hart-array selection state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hasel_q  <= 1'b0;
            hamask_q <= '0;
        end else begin
            hasel_q  <= hasel_d;
            hamask_q <= hamask_d;
        end
    end

    // A write applies the mask it loads in the same cycle.
    assign mask_wr     = w[HASEL] ? hawindow_i : '0;
    assign mask_lat    = hasel_q ? hamask_q : '0;
    assign hasel_rd    = hasel_q;
    assign unused_bits = ^{w[27], w[5:4]};
`else
    assign mask_wr     = '0;
    assign mask_lat    = '0;
    assign hasel_rd    = 1'b0;
    assign unused_bits = ^{w[27], w[HASEL], w[5:4]};
`endif

    dm_hartsel_decode #(.NHARTS(NHARTS)) u_dec_wr (
        .hartsel_i     (hs_wr),
        .mask_i        (mask_wr),
        .sel_o         (sel_wr),
        .nonexistent_o (unused_wr_nonexist)
    );

    dm_hartsel_decode #(.NHARTS(NHARTS)) u_dec_lat (
        .hartsel_i     (hs_lat),
        .mask_i        (mask_lat),
        .sel_o         (sel_lat),
        .nonexistent_o (nonexist_lat)
    );

    // Next state: write effects on the selected harts, hart acks, and wholesale clear while inactive.
    always_comb begin
        act        = wr ? w[DMACTIVE] : dmactive_q;
        dmactive_d = act;
        ndmreset_d = act & (wr ? w[NDMRESET] : ndmreset_q);
        hartsel_d  = ~act ? '0 : wr ? hs_wr[HARTSEL_W-1:0] : hartsel_q;
        halt_d     = halt_q;
        pend_d     = pend_q;
        rack_d     = rack_q;
        haverst_d  = haverst_q;
        rhr_d      = rhr_q;
        hrst_d     = hrst_q;
        for (int i = 0; i < NHARTS; i++) begin
            if (resume_ack_i[i] & pend_q[i]) begin
                pend_d[i] = 1'b0;
                rack_d[i] = 1'b1;
            end
            if (wr & sel_wr[i]) begin
                halt_d[i] = w[HALTREQ];
                hrst_d[i] = w[HARTRESET];
                if (resume_ok & hart_halted_i[i]) begin
                    rack_d[i] = 1'b0;
                    pend_d[i] = 1'b1;
                end
                if (w[ACKHAVERESET]) haverst_d[i] = 1'b0;
                if (w[CLRRESETHALTREQ]) rhr_d[i] = 1'b0;
                if (w[SETRESETHALTREQ]) rhr_d[i] = 1'b1;
            end
            if (hart_reset_done_i[i]) haverst_d[i] = 1'b1;
        end
        if (!act) begin
            halt_d    = '0;
            pend_d    = '0;
            rack_d    = '0;
            haverst_d = '0;
            rhr_d     = '0;
            hrst_d    = '0;
        end
    end

    // Control and per-hart state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmactive_q <= 1'b0;
            ndmreset_q <= 1'b0;
            hartsel_q  <= '0;
            halt_q     <= '0;
            pend_q     <= '0;
            rack_q     <= '0;
            haverst_q  <= '0;
            rhr_q      <= '0;
            hrst_q     <= '0;
        end else begin
            dmactive_q <= dmactive_d;
            ndmreset_q <= ndmreset_d;
            hartsel_q  <= hartsel_d;
            halt_q     <= halt_d;
            pend_q     <= pend_d;
            rack_q     <= rack_d;
            haverst_q  <= haverst_d;
            rhr_q      <= rhr_d;
            hrst_q     <= hrst_d;
        end
    end

    // Readback: per-hart fields come from the single hart at hartsel; write-1 bits read 0.
    always_comb begin
        rd_halt = 1'b0;
        rd_hrst = 1'b0;
        for (int i = 0; i < NHARTS; i++) begin
            if (hs_lat == HARTSEL_MAX_W'(i)) begin
                rd_halt = halt_q[i];
                rd_hrst = hrst_q[i];
            end
        end
        rd            = put_hartsel(hs_lat);
        rd[HALTREQ]   = rd_halt;
        rd[HARTRESET] = rd_hrst;
        rd[HASEL]     = hasel_rd;
        rd[NDMRESET]  = ndmreset_q;
        rd[DMACTIVE]  = dmactive_q;
    end

    assign dmi.dmcont_reg    = rd;
    assign halt_req_o        = halt_q;
    assign resume_req_o      = pend_q;
    assign hart_reset_o      = hrst_q;
    assign resethaltreq_o    = rhr_q;
    assign ndmreset_o        = ndmreset_q;
    assign sel_nonexistent_o = dmactive_q & nonexist_lat;
    assign any_halted_o      = dmactive_q & |(sel_lat & hart_halted_i);
    assign all_halted_o      = dmactive_q & |sel_lat & &(~sel_lat | hart_halted_i);
    assign any_resumeack_o   = dmactive_q & |(sel_lat & rack_q);
    assign all_resumeack_o   = dmactive_q & |sel_lat & &(~sel_lat | rack_q);
    assign any_havereset_o   = dmactive_q & |(sel_lat & haverst_q);
    assign all_havereset_o   = dmactive_q & |sel_lat & &(~sel_lat | haverst_q);
endmodule

// File: tb/tb_dm_control_unit.sv
// tb_dm_control_unit: directed self-checking bench for dm_control_unit (NHARTS=4, HARTSEL_W=10)
module tb_dm_control_unit;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] halt_req_o, resume_req_o, hart_reset_o, resethaltreq_o;
    logic [3:0] hart_halted_i, resume_ack_i, hart_reset_done_i;
    logic       ndmreset_o, sel_nonexistent_o;
    logic       any_halted_o, all_halted_o, any_resumeack_o, all_resumeack_o;
    logic       any_havereset_o, all_havereset_o;
    int         checks = 0;
    int         errors = 0;
`ifdef DM_HART_ARRAY_EN
    logic [3:0] hawindow_i;
`endif

    dm_control_unit_if dmi ();

    dm_control_unit #(.NHARTS(4), .HARTSEL_W(10)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .dmi               (dmi),
`ifdef DM_HART_ARRAY_EN
        .hawindow_i        (hawindow_i),
`endif
        .halt_req_o        (halt_req_o),
        .resume_req_o      (resume_req_o),
        .hart_reset_o      (hart_reset_o),
        .ndmreset_o        (ndmreset_o),
        .resethaltreq_o    (resethaltreq_o),
        .hart_halted_i     (hart_halted_i),
        .resume_ack_i      (resume_ack_i),
        .hart_reset_done_i (hart_reset_done_i),
        .sel_nonexistent_o (sel_nonexistent_o),
        .any_halted_o      (any_halted_o),
        .all_halted_o      (all_halted_o),
        .any_resumeack_o   (any_resumeack_o),
        .all_resumeack_o   (all_resumeack_o),
        .any_havereset_o   (any_havereset_o),
        .all_havereset_o   (all_havereset_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        dmi.dmi_wr    = 1'b1;
        dmi.dmi_wdata = d;
        cyc();
        dmi.dmi_wr    = 1'b0;
        dmi.dmi_wdata = '0;
    endtask

    initial begin
        rst_ni            = 1'b0;
        dmi.dmi_wr        = 1'b0;
        dmi.dmi_wdata     = '0;
        hart_halted_i     = '0;
        resume_ack_i      = '0;
        hart_reset_done_i = '0;
`ifdef DM_HART_ARRAY_EN
        hawindow_i        = '0;
`endif
        cyc();
        cyc();
        chk("rst_reg", dmi.dmcont_reg, 32'h0);
        chk("rst_outs", {halt_req_o, resume_req_o, hart_reset_o, resethaltreq_o}, 32'h0);
        chk("rst_flags", {ndmreset_o, sel_nonexistent_o, any_halted_o, all_halted_o,
                          any_resumeack_o, all_resumeack_o, any_havereset_o, all_havereset_o}, 32'h0);
        rst_ni = 1'b1;
        cyc();

        wr(32'h8000_0001);
        chk("halt0", halt_req_o, 32'h1);
        chk("halt0_reg", dmi.dmcont_reg, 32'h8000_0001);
        wr(32'h0001_0001);
        chk("halt0_kept", halt_req_o, 32'h1);
        chk("sel1_reg", dmi.dmcont_reg, 32'h0001_0001);

        wr(32'h8002_0001);
        hart_halted_i = 4'b0101;
        #1;
        chk("halt2", halt_req_o, 32'h5);
        chk("all_halted2", {any_halted_o, all_halted_o}, 32'h3);
        wr(32'h4002_0001);
        chk("resume_req2", resume_req_o, 32'h4);
        chk("resume_halt", halt_req_o, 32'h1);
        chk("resume_reg", dmi.dmcont_reg, 32'h0002_0001);
        chk("rack_before", all_resumeack_o, 32'h0);
        resume_ack_i = 4'b0100;
        cyc();
        resume_ack_i = '0;
        chk("resume_ack_drop", resume_req_o, 32'h0);
        chk("rack_after", {any_resumeack_o, all_resumeack_o}, 32'h3);
        wr(32'hC002_0001);
        chk("halt_and_resume", resume_req_o, 32'h0);
        chk("halt_and_resume_h", halt_req_o, 32'h5);
        chk("rack_kept", all_resumeack_o, 32'h1);

        wr(32'h0001_0001);
        resume_ack_i = 4'b0010;
        cyc();
        resume_ack_i = '0;
        chk("stray_ack", {resume_req_o, 3'b0, any_resumeack_o}, 32'h0);
        hart_reset_done_i = 4'b0010;
        cyc();
        hart_reset_done_i = '0;
        chk("havereset_set", all_havereset_o, 32'h1);
        wr(32'h1001_0001);
        chk("havereset_ack", any_havereset_o, 32'h0);
        hart_reset_done_i = 4'b0010;
        wr(32'h1001_0001);
        hart_reset_done_i = '0;
        chk("havereset_set_wins", all_havereset_o, 32'h1);

        wr(32'h0001_000D);
        chk("rhr_set_wins", resethaltreq_o, 32'h2);
        wr(32'h0001_0005);
        chk("rhr_clr", resethaltreq_o, 32'h0);
        wr(32'h2001_0003);
        chk("hartreset", {hart_reset_o, 3'b0, ndmreset_o}, 32'h21);
        chk("hartreset_reg", dmi.dmcont_reg, 32'h2001_0003);

        wr(32'h8004_0001);
        chk("nonexist", sel_nonexistent_o, 32'h1);
        chk("nonexist_outs", {halt_req_o, resume_req_o, hart_reset_o, resethaltreq_o}, 32'h5020);
        chk("nonexist_sum", {any_halted_o, all_halted_o, any_resumeack_o, all_resumeack_o,
                             any_havereset_o, all_havereset_o}, 32'h0);
        chk("nonexist_reg", dmi.dmcont_reg, 32'h0004_0001);
        wr(32'h0000_0041);
        chk("hartsel_warl", dmi.dmcont_reg, 32'h0000_0001);

        wr(32'h4002_0001);
        chk("pend_again", resume_req_o, 32'h4);
        wr(32'h0000_0000);
        chk("deact_outs", {halt_req_o, resume_req_o, hart_reset_o, resethaltreq_o}, 32'h0);
        chk("deact_reg", dmi.dmcont_reg, 32'h0);
        chk("deact_flags", {ndmreset_o, any_halted_o, all_havereset_o}, 32'h0);
        resume_ack_i = 4'b0100;
        cyc();
        resume_ack_i = '0;
        wr(32'h0002_0001);
        chk("late_ack_ignored", {resume_req_o, 3'b0, any_resumeack_o}, 32'h0);

        wr(32'h8000_0003);
        chk("pre_async", {halt_req_o, 3'b0, ndmreset_o}, 32'h11);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_outs", {halt_req_o, 3'b0, ndmreset_o}, 32'h0);
        chk("async_reg", dmi.dmcont_reg, 32'h0);
        cyc();
        rst_ni = 1'b1;
        cyc();

`ifdef DM_HART_ARRAY_EN
        hawindow_i = 4'b1010;
        wr(32'h8400_0001);
        hawindow_i = '0;
        chk("array_halt", halt_req_o, 32'hB);
        chk("array_reg", dmi.dmcont_reg, 32'h8400_0001);
`else
        wr(32'h8400_0001);
        chk("hasel_warl", dmi.dmcont_reg, 32'h8000_0001);
        chk("hasel_halt", halt_req_o, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
